// File: rtl/flow_tick_pkg.sv
// Shared definitions for the flow-control tick generator: channel state
// encodings, simulation timing constants and the prescaler config helper.
package flow_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } chan_state_e;

  localparam int unsigned SIM_CYCLES_PER_MS = 300;
  localparam int unsigned SIM_MS_PER_SEC    = 2;

  typedef struct packed {
    logic [31:0] cpm;
    logic [31:0] carry;
  } tick_cfg_t;

  // Cycles per ms and ms per second, shortened in simulation mode.
  function automatic tick_cfg_t tick_cfg_f(input bit sim, input int unsigned clock_freq);
    tick_cfg_t cfg;
    if (sim) begin
      cfg.cpm   = SIM_CYCLES_PER_MS;
      cfg.carry = SIM_MS_PER_SEC;
    end else begin
      cfg.cpm   = clock_freq / 1000;
      cfg.carry = 1000;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/flow_tick_chan.sv
// One tick channel: start/stop FSM, ms window counter with period latch,
// and a pulse stretcher that marks the final window after a stop.
module flow_tick_chan
  import flow_tick_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int PULSE_WIDTH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                pulse_o,
  output logic                last_o,
  output logic                active_o
);

  localparam int RW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  chan_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d, per_new;
  logic [RW-1:0]       rem_q, rem_d;
  logic                start_q, start_rise, fire;
  logic                pulse_q, pulse_d;
  logic                last_q, last_d;
  logic                active_q, active_d;

  always_comb begin
    start_rise = start_i & ~start_q;
    per_new    = (period_i == '0) ? PERIOD_W'(1) : period_i;
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    fire       = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise && !stop_i) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (stop_i) begin
            state_d = ST_IDLE;
          end else if (tick_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            per_d   = per_new;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (tick_i) begin
            if (cnt_q == per_q - PERIOD_W'(1)) begin
              fire  = 1'b1;
              cnt_d = '0;
              per_d = per_new;
            end else begin
              cnt_d = cnt_q + PERIOD_W'(1);
            end
          end
          // A draining channel ignores stop; its next fire is the last one.
          if (state_q == ST_DRAIN) begin
            if (fire) state_d = ST_IDLE;
          end else if (stop_i) begin
            state_d = ST_DRAIN;
          end
        end
      endcase
    end
  end

  always_comb begin
    pulse_d = pulse_q;
    last_d  = last_q;
    rem_d   = rem_q;
    if (en_i) begin
      if (fire) begin
        pulse_d = 1'b1;
        last_d  = (state_q == ST_DRAIN);
        rem_d   = RW'(PULSE_WIDTH - 1);
      end else if (pulse_q) begin
        if (rem_q == '0) begin
          pulse_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          rem_d = rem_q - RW'(1);
        end
      end
    end
  end

  assign active_d = (state_d != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      rem_q    <= '0;
      start_q  <= 1'b0;
      pulse_q  <= 1'b0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      rem_q    <= rem_d;
      start_q  <= start_i;
      pulse_q  <= pulse_d;
      last_q   <= last_d;
      active_q <= active_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign last_o   = last_q;
  assign active_o = active_q;

endmodule

// File: rtl/flow_tick_gen.sv
// Multi-channel flow-control tick generator: shared ms/second prescaler
// feeding CH_NUM independent window-boundary pulse channels.
module flow_tick_gen
  import flow_tick_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 100_000_000,
  parameter              SIM_MODE    = "TRUE",
  parameter int          CH_NUM      = 4,
  parameter int          PERIOD_W    = 16,
  parameter int          PULSE_WIDTH = 1
) (
  input  logic                       i_pluse_clk,
  input  logic                       i_pluse_rst,
  input  logic                       i_en,
  input  logic [CH_NUM-1:0]          i_ch_start,
  input  logic [CH_NUM-1:0]          i_ch_stop,
  input  logic [CH_NUM*PERIOD_W-1:0] i_ch_period_ms,
  output logic                       o_ms_tick,
  output logic                       o_sec_tick,
  output logic [CH_NUM-1:0]          o_ch_pulse,
  output logic [CH_NUM-1:0]          o_ch_pulse_last,
  output logic [CH_NUM-1:0]          o_ch_active
);

  localparam bit        SIM   = (SIM_MODE == "TRUE");
  localparam tick_cfg_t CFG   = tick_cfg_f(SIM, CLOCK_FREQ);
  localparam int        CPM   = int'(CFG.cpm);
  localparam int        CARRY = int'(CFG.carry);
  localparam int        P_W   = (CPM > 1) ? $clog2(CPM) : 1;
  localparam int        S_W   = (CARRY > 1) ? $clog2(CARRY) : 1;

  if (PULSE_WIDTH < 1 || PULSE_WIDTH >= CPM) begin : g_bad_pulse_width
    $error("flow_tick_gen: PULSE_WIDTH must be 1..cycles-per-ms-1");
  end
  if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
    $error("flow_tick_gen: CH_NUM must be 1..16");
  end

  logic [P_W-1:0] p_q, p_d;
  logic [S_W-1:0] s_q, s_d;
  logic           p_wrap;
  logic           ms_tick_q, ms_tick_d;
  logic           sec_tick_q, sec_tick_d;

  // Prescaler holds at zero while disabled so the first tick is CPM cycles after enable.
  always_comb begin
    p_wrap     = (p_q == P_W'(CPM - 1));
    p_d        = '0;
    s_d        = '0;
    ms_tick_d  = 1'b0;
    sec_tick_d = 1'b0;
    if (i_en) begin
      p_d        = p_wrap ? '0 : p_q + P_W'(1);
      s_d        = s_q;
      if (p_wrap) s_d = (s_q == S_W'(CARRY - 1)) ? '0 : s_q + S_W'(1);
      ms_tick_d  = p_wrap;
      sec_tick_d = p_wrap && (s_q == S_W'(CARRY - 1));
    end
  end

  always_ff @(posedge i_pluse_clk) begin
    if (i_pluse_rst) begin
      p_q        <= '0;
      s_q        <= '0;
      ms_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      s_q        <= s_d;
      ms_tick_q  <= ms_tick_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign o_ms_tick  = ms_tick_q;
  assign o_sec_tick = sec_tick_q;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    flow_tick_chan #(
      .PERIOD_W    (PERIOD_W),
      .PULSE_WIDTH (PULSE_WIDTH)
    ) u_chan (
      .clk_i    (i_pluse_clk),
      .rst_i    (i_pluse_rst),
      .en_i     (i_en),
      .tick_i   (ms_tick_q),
      .start_i  (i_ch_start[k]),
      .stop_i   (i_ch_stop[k]),
      .period_i (i_ch_period_ms[k*PERIOD_W +: PERIOD_W]),
      .pulse_o  (o_ch_pulse[k]),
      .last_o   (o_ch_pulse_last[k]),
      .active_o (o_ch_active[k])
    );
  end

endmodule

// File: tb/tb_flow_tick_gen.sv
// Bench for flow_tick_gen: directed timeline scenarios plus randomized traffic,
// all checked every cycle against a countdown-style reference model.
module tb_flow_tick_gen;

  localparam int CH      = 4;
  localparam int PW_BITS = 16;
  localparam int PULSE   = 1;
  localparam int CPM     = 300;
  localparam int CARRY   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [CH-1:0]         start, stop;
  logic [CH*PW_BITS-1:0] period;
  logic                  ms, sec;
  logic [CH-1:0]         pulse, last, active;

  flow_tick_gen #(
    .CLOCK_FREQ  (100_000_000),
    .SIM_MODE    ("TRUE"),
    .CH_NUM      (CH),
    .PERIOD_W    (PW_BITS),
    .PULSE_WIDTH (PULSE)
  ) dut (
    .i_pluse_clk     (clk),
    .i_pluse_rst     (rst),
    .i_en            (en),
    .i_ch_start      (start),
    .i_ch_stop       (stop),
    .i_ch_period_ms  (period),
    .o_ms_tick       (ms),
    .o_sec_tick      (sec),
    .o_ch_pulse      (pulse),
    .o_ch_pulse_last (last),
    .o_ch_active     (active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference model: enabled-cycle counter for ticks, ms-left countdown per channel.
  int run;
  bit m_ms, m_sec;
  bit prev_start [CH];
  bit armed [CH];
  bit live [CH];
  bit drain [CH];
  int left [CH];
  int plen [CH];
  bit plast [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int per_of(input int k);
    int v;
    v = int'(period[k*PW_BITS +: PW_BITS]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic set_period(input int k, input int v);
    period[k*PW_BITS +: PW_BITS] = PW_BITS'(v);
  endtask

  task automatic model_edge();
    bit tick, rise, fire;
    tick = m_ms;
    if (rst) begin
      run = 0; m_ms = 0; m_sec = 0;
      for (int k = 0; k < CH; k++) begin
        prev_start[k] = 0; armed[k] = 0; live[k] = 0; drain[k] = 0;
        left[k] = 0; plen[k] = 0; plast[k] = 0;
      end
      return;
    end
    for (int k = 0; k < CH; k++) begin
      rise = start[k] && !prev_start[k];
      prev_start[k] = start[k];
      fire = 0;
      if (en) begin
        if (live[k] && tick) begin
          if (left[k] == 1) begin
            fire = 1;
            left[k] = per_of(k);
          end else begin
            left[k] = left[k] - 1;
          end
        end
        if (fire) begin
          plen[k] = PULSE;
          plast[k] = drain[k];
        end else if (plen[k] > 0) begin
          plen[k] = plen[k] - 1;
        end
        if (live[k]) begin
          if (fire && drain[k]) begin
            live[k] = 0; drain[k] = 0;
          end else if (stop[k]) begin
            drain[k] = 1;
          end
        end else if (armed[k]) begin
          if (stop[k]) begin
            armed[k] = 0;
          end else if (tick) begin
            armed[k] = 0; live[k] = 1; drain[k] = 0;
            left[k] = per_of(k);
          end
        end else if (rise && !stop[k]) begin
          armed[k] = 1;
        end
      end
    end
    if (en) begin
      run++;
      m_ms  = (run % CPM == 0);
      m_sec = m_ms && ((run / CPM) % CARRY == 0);
    end else begin
      run = 0; m_ms = 0; m_sec = 0;
    end
  endtask

  function automatic logic [CH-1:0] exp_pulse();
    logic [CH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k] = (plen[k] > 0);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_last();
    logic [CH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k] = (plen[k] > 0) && plast[k];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_active();
    logic [CH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k] = armed[k] || live[k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    t++;
    check("ms_tick", ms, m_ms);
    check("sec_tick", sec, m_sec);
    check("ch_pulse", pulse, exp_pulse());
    check("ch_pulse_last", last, exp_last());
    check("ch_active", active, exp_active());
  endtask

  task automatic hold_reset(input int n);
    rst = 1; en = 0; start = '0; stop = '0; period = '0;
    repeat (n) step();
    check("rst_outputs", {ms, sec, pulse, last, active}, '0);
  endtask

  initial begin
    rst = 1; en = 0; start = '0; stop = '0; period = '0;
    hold_reset(3);

    // Enable, basic periods, graceful stop, period 0 vs 1, start+stop collision.
    set_period(0, 3); set_period(1, 0); set_period(2, 1);
    rst = 0; en = 1; t = 0;
    while (t < 2600) begin
      if (t == 10) begin start = 4'b1111; stop[3] = 1; end
      if (t == 20) stop[3] = 0;
      if (t == 1500) stop[0] = 1;
      if (t == 1510) stop[0] = 0;
      step();
      if (t == 40) begin
        check("s2_ch0_armed", active[0], 1);
        check("s4_ch3_idle", active[3], 0);
      end
      if (t == 300) check("s1_ms_300", ms, 1);
      if (t == 301) check("s1_ms_301", ms, 0);
      if (t == 600) check("s1_sec_600", sec, 1);
      if (t == 900) check("s1_sec_900", sec, 0);
      if (t == 601) check("s4_pulse12_601", pulse[2:1], 2'b11);
      if (t == 901) check("s4_pulse12_901", pulse[2:1], 2'b11);
      if (t == 1201) begin
        check("s2_pulse_1201", pulse[0], 1);
        check("s2_last_1201", last[0], 0);
      end
      if (t == 2100) check("s3_active_2100", active[0], 1);
      if (t == 2101) begin
        check("s3_pulse_2101", pulse[0], 1);
        check("s3_last_2101", last[0], 1);
        check("s3_active_2101", active[0], 0);
      end
      if (t == 2401) check("s3_quiet_2401", pulse[0], 0);
    end

    // Enable dropped mid-run: prescaler restarts, channel count resumes.
    hold_reset(2);
    set_period(0, 2);
    rst = 0; en = 1; t = 0;
    while (t < 1700) begin
      if (t == 10) start[0] = 1;
      if (t == 700) en = 0;
      if (t == 1000) en = 1;
      step();
      if (t == 900) check("s5_no_tick_900", ms, 0);
      if (t == 901) check("s5_no_pulse_901", pulse[0], 0);
      if (t == 1300) check("s5_tick_1300", ms, 1);
      if (t == 1301) check("s5_pulse_1301", pulse[0], 1);
      if (t == 1601) check("s5_no_pulse_1601", pulse[0], 0);
    end

    // Reset mid-run with start held high: re-arm from the held level.
    hold_reset(2);
    set_period(0, 2);
    rst = 0; en = 1; t = 0;
    while (t < 2000) begin
      if (t == 10) start[0] = 1;
      if (t == 1000) rst = 1;
      if (t == 1003) rst = 0;
      step();
      if (t == 901) check("s6_pulse_901", pulse[0], 1);
      if (t == 1002) check("s6_rst_outputs", {ms, sec, pulse, last, active}, '0);
      if (t == 1004) check("s6_rearm_1004", active[0], 1);
      if (t == 1604) check("s6_no_pulse_1604", pulse[0], 0);
      if (t == 1904) check("s6_pulse_1904", pulse[0], 1);
    end

    // Randomized traffic against the model.
    hold_reset(2);
    rst = 0; en = 1;
    for (int k = 0; k < CH; k++) set_period(k, $urandom_range(0, 3));
    for (int i = 0; i < 30000; i++) begin
      rst = ($urandom_range(0, 3999) == 0);
      if (en) begin
        if ($urandom_range(0, 2999) == 0) en = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        en = 1;
      end
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 149) == 0) start[k] = ~start[k];
        if (stop[k]) begin
          if ($urandom_range(0, 99) == 0) stop[k] = 0;
        end else if ($urandom_range(0, 1499) == 0) begin
          stop[k] = 1;
        end
        if ($urandom_range(0, 499) == 0) set_period(k, $urandom_range(0, 3));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
